// File: rtl/serial_demux_pkg.sv
// Shared types and constants for the serial demultiplexer: FSM state encoding,
// address-width derivation and the parity sense.
package serial_demux_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_PAR  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic PARITY_EVEN = 1'b0;

    // A two-channel demux still needs one address bit.
    function automatic int calc_addr_w(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/serial_demux_n_bit_down_counter.sv
// Loadable down counter with a zero flag; decrementing stops at zero so the
// count never wraps.
module bit_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    // Count register: load wins over decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);

endmodule

// File: rtl/serial_demux_n.sv
// Framed serial-to-channel demultiplexer: start, address, length, payload and
// optional even-parity bit; payload is steered onto one of NUM_CH serial outputs.
module serial_demux_n
    import serial_demux_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int LEN_W     = 4,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkEn,
    input  logic              SerIn,
    output logic [NUM_CH-1:0] ChOut,
    output logic              SerOutValid,
    output logic [LEN_W-1:0]  Remaining,
    output logic              Done,
    output logic              ParErr,
    output logic              Busy
);

    localparam int ADDR_W = calc_addr_w(NUM_CH);
    localparam int CNT_W  = (LEN_W > ADDR_W) ? LEN_W : ADDR_W;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic                r_par;
    logic                r_parerr;

    logic [ADDR_W:0]     w_addr_shift;
    logic [LEN_W:0]      w_len_shift;
    logic [LEN_W-1:0]    w_len_next;
    logic                w_bc_load;
    logic [CNT_W-1:0]    w_bc_val;
    logic                w_bc_dec;
    logic                w_bc_zero;
    logic [CNT_W-1:0]    w_bc_count_unused;
    logic                w_rem_load;
    logic                w_rem_dec;
    logic                w_rem_zero;
    logic [LEN_W-1:0]    w_rem;
    logic [NUM_CH-1:0]   w_chout;

    assign w_addr_shift = {r_addr, SerIn};
    assign w_len_shift  = {r_len, SerIn};
    assign w_len_next   = w_len_shift[LEN_W-1:0];

    // Counter controls: the field counter indexes address/length bits, the
    // second counter tracks payload bits still to deliver.
    always_comb begin
        w_bc_load  = 1'b0;
        w_bc_val   = '0;
        w_bc_dec   = 1'b0;
        w_rem_load = 1'b0;
        w_rem_dec  = 1'b0;
        if (clkEn) begin
            case (r_state)
                ST_IDLE: begin
                    if (!SerIn) begin
                        w_bc_load = 1'b1;
                        w_bc_val  = CNT_W'(ADDR_W - 1);
                    end else begin
                        w_bc_load = 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (w_bc_zero) begin
                        w_bc_load = 1'b1;
                        w_bc_val  = CNT_W'(LEN_W - 1);
                    end else begin
                        w_bc_dec = 1'b1;
                    end
                end
                ST_LEN: begin
                    if (w_bc_zero) begin
                        w_rem_load = 1'b1;
                    end else begin
                        w_bc_dec = 1'b1;
                    end
                end
                ST_DATA: w_rem_dec = !w_rem_zero;
                default: w_rem_dec = 1'b0;
            endcase
        end else begin
            w_bc_load = 1'b0;
        end
    end

    bit_down_counter #(.WIDTH(CNT_W)) u_bit_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_bc_load),
        .load_val (w_bc_val),
        .dec      (w_bc_dec),
        .count    (w_bc_count_unused),
        .zero     (w_bc_zero)
    );

    bit_down_counter #(.WIDTH(LEN_W)) u_rem_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_rem_load),
        .load_val (w_len_next),
        .dec      (w_rem_dec),
        .count    (w_rem),
        .zero     (w_rem_zero)
    );

    // Frame FSM with field shift registers and the running parity.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_len    <= '0;
            r_par    <= 1'b0;
            r_parerr <= 1'b0;
        end else if (clkEn) begin
            case (r_state)
                ST_IDLE: begin
                    if (!SerIn) begin
                        r_state <= ST_ADDR;
                        r_par   <= PARITY_EVEN;
                    end
                end
                ST_ADDR: begin
                    r_addr <= w_addr_shift[ADDR_W-1:0];
                    r_par  <= r_par ^ SerIn;
                    if (w_bc_zero) begin
                        r_state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    r_len <= w_len_next;
                    r_par <= r_par ^ SerIn;
                    if (w_bc_zero) begin
                        if (w_len_next != '0) begin
                            r_state <= ST_DATA;
                        end else begin
                            r_state <= (PARITY_EN != 0) ? ST_PAR : ST_DONE;
                        end
                    end
                end
                ST_DATA: begin
                    r_par <= r_par ^ SerIn;
                    if (w_rem == LEN_W'(1)) begin
                        r_state <= (PARITY_EN != 0) ? ST_PAR : ST_DONE;
                    end
                end
                ST_PAR: begin
                    r_parerr <= r_par ^ SerIn;
                    r_state  <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Only the addressed channel follows the line, and only during payload.
    always_comb begin
        w_chout = '0;
        if (r_state == ST_DATA) begin
            w_chout[r_addr] = SerIn;
        end else begin
            w_chout = '0;
        end
    end

    assign ChOut       = w_chout;
    assign SerOutValid = (r_state == ST_DATA);
    assign Remaining   = w_rem;
    assign Done        = (r_state == ST_DONE);
    assign ParErr      = r_parerr;
    assign Busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_demux_n.sv
// Self-checking bench for serial_demux_n: frames are scored cycle by cycle
// against expectations computed from frame position arithmetic.
module tb_serial_demux_n;

    localparam int NUM_CH = 4;
    localparam int LEN_W  = 4;
    localparam int ADDR_W = 2;
    localparam int HDR    = 1 + ADDR_W + LEN_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clkEn = 1'b1;
    logic SerIn = 1'b1;

    logic [3:0] ch_p, ch_n, rem_p, rem_n;
    logic v_p, v_n, d_p, d_n, pe_p, pe_n, b_p, b_n;

    logic [3:0] o_ch, o_rem;
    logic o_v, o_d, o_pe, o_b;

    int errors = 0;
    int checks = 0;
    logic use_p = 1'b1;
    logic prev_parerr = 1'b0;

    always #5 clk = ~clk;

    serial_demux_n #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .PARITY_EN(1)) dut_p (
        .clk(clk), .rst(rst), .clkEn(clkEn), .SerIn(SerIn),
        .ChOut(ch_p), .SerOutValid(v_p), .Remaining(rem_p),
        .Done(d_p), .ParErr(pe_p), .Busy(b_p)
    );

    serial_demux_n #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .PARITY_EN(0)) dut_n (
        .clk(clk), .rst(rst), .clkEn(clkEn), .SerIn(SerIn),
        .ChOut(ch_n), .SerOutValid(v_n), .Remaining(rem_n),
        .Done(d_n), .ParErr(pe_n), .Busy(b_n)
    );

    always_comb begin
        o_ch  = use_p ? ch_p  : ch_n;
        o_rem = use_p ? rem_p : rem_n;
        o_v   = use_p ? v_p   : v_n;
        o_d   = use_p ? d_p   : d_n;
        o_pe  = use_p ? pe_p  : pe_n;
        o_b   = use_p ? b_p   : b_n;
    end

    function automatic logic frame_bit(int k, int addr, int len, logic [15:0] data,
                                       logic parbit, logic pe, logic done_bit);
        int d;
        d = HDR + len + int'(pe);
        if (k == 0) return 1'b0;
        if (k <= ADDR_W) return addr[ADDR_W - k];
        if (k < HDR) return len[LEN_W - 1 - (k - 1 - ADDR_W)];
        if (k < HDR + len) return data[k - HDR];
        if (pe && k == HDR + len) return parbit;
        if (k == d) return done_bit;
        return 1'b1;
    endfunction

    function automatic logic even_bit(int addr, int len, logic [15:0] data);
        int ones;
        ones = 0;
        for (int i = 0; i < ADDR_W; i++) ones += addr[i];
        for (int i = 0; i < LEN_W; i++) ones += len[i];
        for (int i = 0; i < len; i++) ones += int'(data[i]);
        return logic'(ones % 2);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; clkEn = 1'b1; SerIn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        prev_parerr = 1'b0;
    endtask

    // Drive one frame (bit k held for `per` clocks, enabled on the last) and
    // score every clock against the positional model.
    task automatic run_frame(input int addr, input int len, input logic [15:0] data,
                             input logic par_good, input int per,
                             input logic done_bit, input int idle_after);
        logic pe, parbit, new_pe, b, ev, ed, eb, epe;
        logic [3:0] ech, erem;
        int dcyc, k;
        pe     = use_p;
        parbit = even_bit(addr, len, data) ^ !par_good;
        new_pe = pe ? !par_good : prev_parerr;
        dcyc   = HDR + len + int'(pe);
        for (int c = 0; c < (dcyc + 1 + idle_after) * per; c++) begin
            k = c / per;
            @(negedge clk);
            clkEn = (c % per == per - 1);
            b = frame_bit(k, addr, len, data, parbit, pe, done_bit);
            SerIn = b;
            #1;
            ev   = (k >= HDR) && (k < HDR + len);
            erem = ev ? 4'(len - (k - HDR)) : 4'd0;
            ech  = (ev && b) ? 4'(1 << addr) : 4'd0;
            ed   = (k == dcyc);
            eb   = (k >= 1) && (k <= dcyc);
            epe  = (k >= dcyc) ? new_pe : prev_parerr;
            checks += 6;
            if (o_ch !== ech) begin errors++; $display("FAIL chout k=%0d clk=%0d got=%b exp=%b", k, c, o_ch, ech); end
            if (o_v !== ev) begin errors++; $display("FAIL valid k=%0d clk=%0d got=%b exp=%b", k, c, o_v, ev); end
            if (o_rem !== erem) begin errors++; $display("FAIL remaining k=%0d clk=%0d got=%0d exp=%0d", k, c, o_rem, erem); end
            if (o_d !== ed) begin errors++; $display("FAIL done k=%0d clk=%0d got=%b exp=%b", k, c, o_d, ed); end
            if (o_b !== eb) begin errors++; $display("FAIL busy k=%0d clk=%0d got=%b exp=%b", k, c, o_b, eb); end
            if (o_pe !== epe) begin errors++; $display("FAIL parerr k=%0d clk=%0d got=%b exp=%b", k, c, o_pe, epe); end
        end
        prev_parerr = new_pe;
        clkEn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks += 2;
        if ({ch_p, v_p, rem_p, d_p, pe_p, b_p} !== 13'd0) begin
            errors++; $display("FAIL reset_p got=%h exp=0", {ch_p, v_p, rem_p, d_p, pe_p, b_p});
        end
        if ({ch_n, v_n, rem_n, d_n, pe_n, b_n} !== 13'd0) begin
            errors++; $display("FAIL reset_n got=%h exp=0", {ch_n, v_n, rem_n, d_n, pe_n, b_n});
        end
    endtask

    task automatic test_parity();
        use_p = 1'b1;
        do_reset();
        run_frame(2, 3, 16'b101, 1'b1, 1, 1'b1, 2);
        run_frame(2, 3, 16'b101, 1'b0, 1, 1'b1, 3);
        run_frame(1, 2, 16'b10, 1'b1, 1, 1'b1, 1);
    endtask

    task automatic test_len_zero();
        use_p = 1'b0;
        do_reset();
        run_frame(3, 0, 16'h0, 1'b1, 1, 1'b1, 2);
        use_p = 1'b1;
        do_reset();
        run_frame(3, 0, 16'h0, 1'b0, 1, 1'b1, 2);
    endtask

    task automatic test_clken();
        use_p = 1'b1;
        do_reset();
        run_frame(1, 2, 16'b01, 1'b1, 4, 1'b1, 1);
    endtask

    task automatic test_reset_mid();
        logic [15:0] data;
        logic parbit;
        use_p = 1'b1;
        do_reset();
        data = 16'($urandom);
        parbit = even_bit(1, 5, data);
        for (int k = 0; k <= HDR + 3; k++) begin
            @(negedge clk);
            SerIn = frame_bit(k, 1, 5, data, parbit, 1'b1, 1'b1);
        end
        #1;
        checks++;
        if (rem_p !== 4'd2) begin errors++; $display("FAIL mid_rem_before got=%0d exp=2", rem_p); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        SerIn = 1'b1;
        #1;
        checks += 4;
        if (ch_p !== 4'd0) begin errors++; $display("FAIL mid_chout got=%b exp=0000", ch_p); end
        if (rem_p !== 4'd0) begin errors++; $display("FAIL mid_rem got=%0d exp=0", rem_p); end
        if (b_p !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", b_p); end
        if (v_p !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", v_p); end
        prev_parerr = 1'b0;
        run_frame(0, 4, 16'b1011, 1'b1, 1, 1'b1, 1);
    endtask

    task automatic test_back_to_back();
        use_p = 1'b1;
        do_reset();
        run_frame(0, 3, 16'b110, 1'b1, 1, 1'b0, 0);
        run_frame(3, 3, 16'b011, 1'b1, 1, 1'b0, 0);
        run_frame(2, 1, 16'b1, 1'b0, 1, 1'b1, 1);
    endtask

    task automatic test_random();
        use_p = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 16'($urandom),
                      1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)));
        end
        use_p = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 16'($urandom),
                      1'b1, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_parity();
        test_len_zero();
        test_clken();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
